// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_PC  = 32'd0;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  // depth must be a power of two
  function automatic logic [31:0] mask_pc(
    input logic [31:0] pc,
    input int unsigned depth
  );
    return pc & (depth - 1);
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating 32-bit event counter with enable.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && count != '1) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, IF/ID register, stall/redirect/halt.
// Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter int unsigned          MEM_DEPTH = 256,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = PC_WIDTH'(DEF_RESET_PC),
  parameter logic [31:0]          HALT_WORD = DEF_HALT_WORD
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] pc_out,
  input  logic [31:0]         instr_in,
  input  logic                stall,
  input  logic                branch_valid,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                if_valid,
  output logic [31:0]         if_instr,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic                halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  fetch_state_t state_q, state_d;

  logic redirect;
  logic capture;
  logic halt_hit;
  logic stall_cyc;

  logic [PC_WIDTH-1:0] tgt_m;
  logic [PC_WIDTH-1:0] pc_inc;

  assign tgt_m  = PC_WIDTH'(mask_pc(32'(branch_target), MEM_DEPTH));
  assign pc_inc = PC_WIDTH'(mask_pc(32'(pc_out + PC_WIDTH'(1)), MEM_DEPTH));

  always_comb begin
    state_d   = state_q;
    redirect  = 1'b0;
    capture   = 1'b0;
    halt_hit  = 1'b0;
    stall_cyc = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (branch_valid) begin
          redirect = 1'b1;
        end else if (stall) begin
          stall_cyc = 1'b1;
        end else if (instr_in == HALT_WORD) begin
          halt_hit = 1'b1;
          state_d  = HALTED;
        end else begin
          capture = 1'b1;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_out   <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      state_q <= state_d;
      if (redirect) begin
        pc_out   <= tgt_m;
        if_valid <= 1'b0;
      end else if (capture) begin
        if_instr <= instr_in;
        if_pc    <= pc_out;
        if_valid <= 1'b1;
        pc_out   <= pc_inc;
      end else if (halt_hit) begin
        if_valid <= 1'b0;
      end
    end
  end

  assign halted = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (capture),
    .count (perf_fetch_cnt)
  );

  fetch_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_cyc),
    .count (perf_stall_cnt)
  );
`else
  logic unused_stall;
  assign unused_stall = stall_cyc;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed plan plus random run
// against a cycle-level behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  logic [31:0] mem [256];

  assign instr_in = mem[pc_out[7:0]];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_out        (pc_out),
    .instr_in      (instr_in),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // model: phase 0 = settling after reset, 1 = running, 2 = stopped
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_ifpc;
  logic        m_valid;
  int unsigned m_fetches, m_stalls;

  task automatic model_reset();
    m_phase = 0;
    m_pc = 0;
    m_instr = 0;
    m_ifpc = 0;
    m_valid = 0;
    m_fetches = 0;
    m_stalls = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"}, pc_out, m_pc);
    check({tag, ".valid"}, 32'(if_valid), 32'(m_valid));
    check({tag, ".halted"}, 32'(halted), 32'(m_phase == 2));
    if (m_valid) begin
      check({tag, ".instr"}, if_instr, m_instr);
      check({tag, ".ifpc"}, if_pc, m_ifpc);
    end
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".pfetch"}, perf_fetch_cnt, m_fetches);
    check({tag, ".pstall"}, perf_stall_cnt, m_stalls);
`endif
  endtask

  // apply inputs for one cycle, advance model, compare after edge
  task automatic step(input bit st, input bit bv, input logic [31:0] bt,
                      input string tag);
    stall = st;
    branch_valid = bv;
    branch_target = bt;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (bv) begin
        m_pc = bt % 256;
        m_valid = 0;
      end else if (st) begin
        m_stalls++;
      end else if (mem[m_pc] == HW) begin
        m_valid = 0;
        m_phase = 2;
      end else begin
        m_instr = mem[m_pc];
        m_ifpc = m_pc;
        m_valid = 1;
        m_pc = (m_pc + 1) % 256;
        m_fetches++;
      end
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pc"}, pc_out, 32'd0);
    check({tag, ".valid"}, 32'(if_valid), 32'd0);
    check({tag, ".instr"}, if_instr, 32'd0);
    check({tag, ".ifpc"}, if_pc, 32'd0);
    check({tag, ".halted"}, 32'(halted), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".pfetch"}, perf_fetch_cnt, 32'd0);
    check({tag, ".pstall"}, perf_stall_cnt, 32'd0);
`endif
  endtask

  task automatic do_reset(input bit st);
    stall = st;
    branch_valid = 0;
    #2;
    rst_n = 0;
    #1;
    check_reset_vals("rst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    stall = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = HW;
    for (int i = 0; i < 8; i++) mem[i] = 32'h11 * (i + 1);
    model_reset();
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1;

    // 1: boot then free run
    step(0, 0, 0, "boot");
    check("boot_valid", 32'(if_valid), 32'd0);
    step(0, 0, 0, "run0");
    check("run0_instr", if_instr, 32'h11);
    step(0, 0, 0, "run1");
    step(0, 0, 0, "run2");
    check("run2_ifpc", if_pc, 32'd2);

    // 2: stall three cycles at if_pc=2
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, "stall");
      check("stall_ifpc", if_pc, 32'd2);
      check("stall_pc", pc_out, 32'd3);
    end
    step(0, 0, 0, "resume");
    check("resume_ifpc", if_pc, 32'd3);

    // 3: branch at pc_out=4 to 0x105 (masked to 5)
    step(0, 1, 32'h105, "br");
    check("br_pc", pc_out, 32'd5);
    check("br_valid", 32'(if_valid), 32'd0);
    step(0, 0, 0, "br_tgt");
    check("br_tgt_ifpc", if_pc, 32'd5);
    check("br_tgt_instr", if_instr, 32'h66);

    // 4: branch during stall
    step(1, 1, 32'd2, "brst");
    check("brst_pc", pc_out, 32'd2);
    step(1, 0, 0, "brst_hold");
    step(0, 0, 0, "brst_go");
    check("brst_ifpc", if_pc, 32'd2);

    // 5: wrap and halt
    mem[255] = 32'hAA;
    mem[0] = 32'hBB;
    mem[1] = HW;
    step(0, 1, 32'd255, "wrap_br");
    step(0, 0, 0, "wrap255");
    check("wrap255_ifpc", if_pc, 32'd255);
    step(0, 0, 0, "wrap0");
    check("wrap0_ifpc", if_pc, 32'd0);
    check("wrap0_instr", if_instr, 32'hBB);
    step(0, 0, 0, "halt");
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", pc_out, 32'd1);
    step(0, 1, 32'd7, "halt_br");
    check("halt_br_pc", pc_out, 32'd1);
    step(1, 0, 0, "halt_st");

    // 6: async reset mid-stall
    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + i;
    do_reset(0);
    step(0, 0, 0, "r_boot");
    step(0, 0, 0, "r_run");
    step(1, 0, 0, "r_st");
    do_reset(1);

    // random run
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 59) == 0) ? HW : $urandom;
    step(0, 0, 0, "rnd_boot");
    for (int c = 0; c < 3000; c++) begin
      bit st, bv;
      logic [31:0] bt;
      st = ($urandom_range(0, 9) < 3);
      bv = ($urandom_range(0, 9) == 0);
      bt = $urandom;
      step(st, bv, bt, "rnd");
      if (m_phase == 2 && $urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 256; i++)
          mem[i] = ($urandom_range(0, 59) == 0) ? HW : $urandom;
        do_reset(st);
        step(0, 0, 0, "rnd_boot");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
